rtc_pps_gen: RTL and testbench
==============================

// Module: rtc_pps_gen
// PURPOSE
//  Downstream consumer of the RTC PTP time outputs (time_ptp_sec/time_ptp_ns), running on rtc_clk.
//  Generates a 1PPS pulse on every whole-second rollover and a one-shot trigger when RTC time
//  reaches a programmed target. Detects discontinuous time (loads/steps) so they never make a false PPS.
// PARAMETERS
//  PPS_WIDTH_CYC   16   pps_out high time in clk cycles; legal range 1..65535
//  TRIG_WIDTH_CYC  4    trig_out high time in clk cycles; legal range 1..65535
// PORTS
//  clk           in   1   rtc clock; the only clock
//  rst           in   1   asynchronous, active-low reset
//  time_ptp_ns   in   32  RTC nanoseconds, 0..999_999_999
//  time_ptp_sec  in   48  RTC seconds
//  pps_en        in   1   level; enables PPS detection
//  tgt_ld        in   1   1-cycle strobe; latch tgt_sec/tgt_ns and arm
//  tgt_sec       in   48  target seconds, sampled on tgt_ld
//  tgt_ns        in   32  target nanoseconds, sampled on tgt_ld
//  tgt_cancel    in   1   1-cycle strobe; disarm
//  pps_out       out  1   PPS pulse, PPS_WIDTH_CYC cycles wide
//  pps_cnt       out  32  count of generated PPS pulses; wraps 2^32-1 -> 0
//  time_jump     out  1   1-cycle flag on a non-continuous seconds change
//  tgt_armed     out  1   target armed
//  tgt_fire      out  1   1-cycle flag when the target is reached
//  tgt_late      out  1   sticky; target was already passed when armed
//  trig_out      out  1   trigger pulse, TRIG_WIDTH_CYC cycles wide
// BEHAVIOUR
//  Reset (rst=0, async): every output 0, all internal registers 0, FSM=IDLE, valid=0.
//  Input stage, edge k: time_q <= {sec,ns}; time_qq <= time_q; valid <= {valid[0],1}.
//    Comparisons use time_q/time_qq and are enabled only when valid==2'b11.
//  Second change, registered at edge k+1 (outputs 2 edges after the input changes):
//    sec_q == sec_qq+1 (mod 2^48): rollover.
//      If pps_en: pps_out<=1, width counter<=PPS_WIDTH_CYC-1, pps_cnt+=1.
//    Any other sec_q != sec_qq: time_jump<=1 for 1 cycle; no PPS, no count.
//    Backward step within one second (ns decreases, sec unchanged) also sets time_jump.
//  PPS width counter: pps_out deasserts when counter==0 at the edge; a rollover while high reloads it.
//    pps_en=0 blocks new pulses only; a pulse already in progress completes.
//  Target FSM, 80-bit unsigned compare now={sec_q,ns_q} vs tgt={tgt_sec,tgt_ns}:
//    IDLE  : tgt_ld -> latch target, tgt_late<=0, go CHECK.
//    CHECK : one cycle. If now>=tgt: tgt_fire<=1, tgt_late<=1, go IDLE.
//            Otherwise go ARMED. tgt_armed=1 in CHECK and ARMED.
//    ARMED : now>=tgt -> tgt_fire<=1, trig_out starts, go IDLE. tgt_late stays 0.
//            A forward step past the target fires normally; a backward step keeps waiting.
//    CHECK fire also starts trig_out.
//    tgt_cancel in CHECK/ARMED -> IDLE with no fire.
//  Simultaneous events:
//    tgt_ld beats tgt_cancel. tgt_ld in CHECK/ARMED re-latches, clears tgt_late, goes CHECK.
//    tgt_ld in the same cycle as a fire condition suppresses that fire.
//    Comparison is disabled until valid==2'b11; CHECK/ARMED hold during that time.
//  trig counter: retrigger while high reloads TRIG_WIDTH_CYC-1; deasserts when the counter hits 0.
//  tgt_late is sticky until the next tgt_ld or reset.
//  Reset mid-pulse or mid-arm: everything clears immediately; no pulse resumes.
// TESTING
//  1. sec 5 ns 999_999_990 -> sec 6 ns 2, pps_en=1, PPS_WIDTH_CYC=16
//     -> pps_out high exactly 16 cycles starting 2 edges after the change; pps_cnt 0->1.
//  2. sec jumps 6 -> 100
//     -> time_jump one cycle; no pps_out; pps_cnt unchanged. Repeat with ns 500 -> 100, same sec -> time_jump.
//  3. Target {10,500}; time ramps from {10,0} in 8ns steps
//     -> tgt_fire one cycle when ns first >=500; trig_out high 4 cycles; tgt_late=0; tgt_armed falls.
//  4. Time at {20,0}, tgt_ld {19,0}
//     -> CHECK fires next cycle; tgt_late=1 until the next tgt_ld.
//  5. Arm {30,0}; tgt_cancel at {29,x} -> no fire at 30. tgt_ld and tgt_cancel in the same cycle -> armed.
//  6. Assert rst mid-PPS and while armed -> all outputs 0 at once.
//     After release, first 2 cycles produce no pps_out/time_jump whatever the input; pps_cnt=0 -> wraps after 2^32 rollovers.

Source files
------------

// File: rtl/rtc_pps_gen.sv
// rtc_pps_gen: 1PPS and one-shot target trigger generator driven by the RTC PTP time.
// Time is registered twice so that consecutive samples can be compared; a seconds
// increment of exactly one makes a PPS pulse, any other seconds change (or a
// backward nanosecond step) is flagged as a time jump instead. A small target
// FSM compares the current time against a latched 80-bit target and fires a
// stretched trigger pulse when it is reached.
module rtc_pps_gen #(
    parameter int unsigned PPS_WIDTH_CYC  = 16,
    parameter int unsigned TRIG_WIDTH_CYC = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] time_ptp_ns,
    input  logic [47:0] time_ptp_sec,
    input  logic        pps_en,
    input  logic        tgt_ld,
    input  logic [47:0] tgt_sec,
    input  logic [31:0] tgt_ns,
    input  logic        tgt_cancel,
    output logic        pps_out,
    output logic [31:0] pps_cnt,
    output logic        time_jump,
    output logic        tgt_armed,
    output logic        tgt_fire,
    output logic        tgt_late,
    output logic        trig_out
);

    localparam logic [15:0] PPS_RELOAD  = 16'(PPS_WIDTH_CYC - 1);
    localparam logic [15:0] TRIG_RELOAD = 16'(TRIG_WIDTH_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_ARMED = 2'd2
    } state_t;

    // Input pipeline: newest sample, previous sample, and a fill indicator.
    logic [79:0] time_q_r;
    logic [79:0] time_qq_r;
    logic [1:0]  valid_r;

    // Pulse stretchers and target state.
    logic [15:0] pps_wcnt_r;
    logic [15:0] trig_wcnt_r;
    state_t      state_r;
    logic [79:0] tgt_r;

    // Decoded comparison results.
    logic        cmp_en_s;
    logic [47:0] sec_q_s;
    logic [47:0] sec_qq_s;
    logic [31:0] ns_q_s;
    logic [31:0] ns_qq_s;
    logic [47:0] sec_next_s;
    logic        is_roll_s;
    logic        rollover_s;
    logic        pps_start_s;
    logic        jump_s;
    logic        now_ge_tgt_s;
    logic        fire_s;

    assign cmp_en_s     = (valid_r == 2'b11);
    assign sec_q_s      = time_q_r[79:32];
    assign ns_q_s       = time_q_r[31:0];
    assign sec_qq_s     = time_qq_r[79:32];
    assign ns_qq_s      = time_qq_r[31:0];
    assign sec_next_s   = sec_qq_s + 48'd1;
    assign is_roll_s    = (sec_q_s == sec_next_s);
    assign rollover_s   = cmp_en_s & is_roll_s;
    assign pps_start_s  = rollover_s & pps_en;
    // A seconds change other than +1, or ns going backwards within the same second.
    assign jump_s       = cmp_en_s & ((sec_q_s != sec_qq_s) ? ~is_roll_s : (ns_q_s < ns_qq_s));
    assign now_ge_tgt_s = (time_q_r >= tgt_r);

    // Fire decision: a new load or a cancel in the same cycle takes precedence over firing.
    always_comb begin
        fire_s = 1'b0;
        if (((state_r == ST_CHECK) || (state_r == ST_ARMED)) && !tgt_ld && !tgt_cancel &&
            cmp_en_s && now_ge_tgt_s) begin
            fire_s = 1'b1;
        end else begin
            fire_s = 1'b0;
        end
    end

    // Input stage: two-deep time history plus fill tracking after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            time_q_r  <= 80'd0;
            time_qq_r <= 80'd0;
            valid_r   <= 2'b00;
        end else begin
            time_q_r  <= {time_ptp_sec, time_ptp_ns};
            time_qq_r <= time_q_r;
            valid_r   <= {valid_r[0], 1'b1};
        end
    end

    // PPS pulse: start or reload on an enabled rollover, otherwise count the width down.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pps_out    <= 1'b0;
            pps_wcnt_r <= 16'd0;
            pps_cnt    <= 32'd0;
        end else if (pps_start_s) begin
            pps_out    <= 1'b1;
            pps_wcnt_r <= PPS_RELOAD;
            pps_cnt    <= pps_cnt + 32'd1;
        end else if (pps_out) begin
            if (pps_wcnt_r == 16'd0) begin
                pps_out <= 1'b0;
            end else begin
                pps_wcnt_r <= pps_wcnt_r - 16'd1;
            end
        end
    end

    // Time jump flag: single-cycle indication of a discontinuous time change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            time_jump <= 1'b0;
        end else begin
            time_jump <= jump_s;
        end
    end

    // Target FSM: latch/arm, first-cycle late check, wait for the target, cancel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            tgt_r     <= 80'd0;
            tgt_armed <= 1'b0;
            tgt_fire  <= 1'b0;
            tgt_late  <= 1'b0;
        end else begin
            tgt_fire <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (tgt_ld) begin
                        tgt_r     <= {tgt_sec, tgt_ns};
                        tgt_late  <= 1'b0;
                        tgt_armed <= 1'b1;
                        state_r   <= ST_CHECK;
                    end
                end
                ST_CHECK, ST_ARMED: begin
                    if (tgt_ld) begin
                        tgt_r     <= {tgt_sec, tgt_ns};
                        tgt_late  <= 1'b0;
                        tgt_armed <= 1'b1;
                        state_r   <= ST_CHECK;
                    end else if (tgt_cancel) begin
                        tgt_armed <= 1'b0;
                        state_r   <= ST_IDLE;
                    end else if (fire_s) begin
                        tgt_fire  <= 1'b1;
                        tgt_armed <= 1'b0;
                        state_r   <= ST_IDLE;
                        // Only a target already passed at arm time counts as late.
                        if (state_r == ST_CHECK) begin
                            tgt_late <= 1'b1;
                        end
                    end else if (cmp_en_s) begin
                        state_r <= ST_ARMED;
                    end
                end
                default: begin
                    tgt_armed <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    // Trigger pulse: start or reload on fire, otherwise count the width down.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trig_out    <= 1'b0;
            trig_wcnt_r <= 16'd0;
        end else if (fire_s) begin
            trig_out    <= 1'b1;
            trig_wcnt_r <= TRIG_RELOAD;
        end else if (trig_out) begin
            if (trig_wcnt_r == 16'd0) begin
                trig_out <= 1'b0;
            end else begin
                trig_wcnt_r <= trig_wcnt_r - 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_rtc_pps_gen.sv
// Testbench for rtc_pps_gen: a vector table for the PPS/jump path, hand sequences
// for the target FSM and reset corners, then randomized time with a reference model.
module tb_rtc_pps_gen;

    localparam int unsigned PPS_W  = 16;
    localparam int unsigned TRIG_W = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_ns;
    logic [47:0] in_sec;
    logic        pps_en;
    logic        tgt_ld;
    logic [47:0] tgt_sec_i;
    logic [31:0] tgt_ns_i;
    logic        tgt_cancel;
    logic        pps_out;
    logic [31:0] pps_cnt;
    logic        time_jump;
    logic        tgt_armed;
    logic        tgt_fire;
    logic        tgt_late;
    logic        trig_out;

    int n_checks = 0;
    int n_err    = 0;
    int n_fire   = 0;
    int n_trig   = 0;

    always #5 clk = ~clk;

    rtc_pps_gen #(.PPS_WIDTH_CYC(PPS_W), .TRIG_WIDTH_CYC(TRIG_W)) dut (
        .clk(clk), .rst(rst),
        .time_ptp_ns(in_ns), .time_ptp_sec(in_sec),
        .pps_en(pps_en), .tgt_ld(tgt_ld), .tgt_sec(tgt_sec_i), .tgt_ns(tgt_ns_i),
        .tgt_cancel(tgt_cancel),
        .pps_out(pps_out), .pps_cnt(pps_cnt), .time_jump(time_jump),
        .tgt_armed(tgt_armed), .tgt_fire(tgt_fire), .tgt_late(tgt_late), .trig_out(trig_out)
    );

    // ---------------- reference model ----------------
    // Times sampled since reset, newest first (only the last two matter).
    logic [79:0] m_hist[$];
    longint      m_edge;
    longint      m_last_pps;
    longint      m_last_trig;
    bit          m_have_pps;
    bit          m_have_trig;
    logic [31:0] m_cnt;
    bit          m_jump;
    bit          m_armed;
    bit          m_fresh;
    bit          m_late;
    bit          m_fire;
    logic [79:0] m_tgt;

    task automatic model_reset();
        m_hist.delete();
        m_edge = 0; m_last_pps = 0; m_last_trig = 0;
        m_have_pps = 1'b0; m_have_trig = 1'b0; m_cnt = 32'd0;
        m_jump = 1'b0; m_armed = 1'b0; m_fresh = 1'b0; m_late = 1'b0; m_fire = 1'b0;
        m_tgt = 80'd0;
    endtask

    task automatic model_edge();
        logic [47:0] s_now, s_prv, s_inc;
        logic [31:0] n_now, n_prv;
        bit ok;
        ok = (m_hist.size() >= 2);
        m_edge++;
        m_jump = 1'b0;
        m_fire = 1'b0;
        if (ok) begin
            s_now = m_hist[0][79:32]; n_now = m_hist[0][31:0];
            s_prv = m_hist[1][79:32]; n_prv = m_hist[1][31:0];
            s_inc = s_prv + 48'd1;
            if (s_now == s_inc) begin
                if (pps_en) begin
                    m_have_pps = 1'b1; m_last_pps = m_edge; m_cnt = m_cnt + 32'd1;
                end
            end else if (s_now != s_prv) begin
                m_jump = 1'b1;
            end else if (n_now < n_prv) begin
                m_jump = 1'b1;
            end
        end
        if (tgt_ld) begin
            m_tgt = {tgt_sec_i, tgt_ns_i}; m_armed = 1'b1; m_fresh = 1'b1; m_late = 1'b0;
        end else if (m_armed && tgt_cancel) begin
            m_armed = 1'b0;
        end else if (m_armed && ok) begin
            if (m_hist[0] >= m_tgt) begin
                m_fire = 1'b1; m_late = m_fresh; m_armed = 1'b0;
                m_have_trig = 1'b1; m_last_trig = m_edge;
            end else begin
                m_fresh = 1'b0;
            end
        end
        m_hist.push_front({in_sec, in_ns});
        if (m_hist.size() > 2) void'(m_hist.pop_back());
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock: DUT and model consume the same inputs, outputs compared on the falling edge.
    task automatic step();
        bit e_pps, e_trig;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        e_pps  = m_have_pps && ((m_edge - m_last_pps) < longint'(PPS_W));
        e_trig = m_have_trig && ((m_edge - m_last_trig) < longint'(TRIG_W));
        chk("pps_out",   64'(pps_out),   64'(e_pps));
        chk("pps_cnt",   64'(pps_cnt),   64'(m_cnt));
        chk("time_jump", 64'(time_jump), 64'(m_jump));
        chk("tgt_armed", 64'(tgt_armed), 64'(m_armed));
        chk("tgt_fire",  64'(tgt_fire),  64'(m_fire));
        chk("tgt_late",  64'(tgt_late),  64'(m_late));
        chk("trig_out",  64'(trig_out),  64'(e_trig));
        if (tgt_fire) n_fire++;
        if (trig_out) n_trig++;
    endtask

    // Asynchronous reset in mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset();
        #2;
        rst = 1'b0;
        #1;
        chk("rst_pps_out",   64'(pps_out),   64'd0);
        chk("rst_pps_cnt",   64'(pps_cnt),   64'd0);
        chk("rst_time_jump", 64'(time_jump), 64'd0);
        chk("rst_tgt_armed", 64'(tgt_armed), 64'd0);
        chk("rst_tgt_fire",  64'(tgt_fire),  64'd0);
        chk("rst_tgt_late",  64'(tgt_late),  64'd0);
        chk("rst_trig_out",  64'(trig_out),  64'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    typedef struct {
        logic [47:0] sec;
        logic [31:0] ns;
        logic        en;
        int          reps;
        logic        pps;
        logic        jump;
        logic [31:0] cnt;
    } vec_t;

    vec_t vt[18];
    int   fire_ns;
    logic [31:0] last_ns;

    initial begin
        // Expected outputs are those seen after each clock that samples the row's inputs.
        vt[0]  = '{48'd5,   32'd999_999_990, 1'b1, 2,  1'b0, 1'b0, 32'd0};
        vt[1]  = '{48'd6,   32'd2,           1'b1, 1,  1'b0, 1'b0, 32'd0};
        vt[2]  = '{48'd6,   32'd10,          1'b1, 1,  1'b1, 1'b0, 32'd1};
        vt[3]  = '{48'd6,   32'd10,          1'b1, 15, 1'b1, 1'b0, 32'd1};
        vt[4]  = '{48'd6,   32'd10,          1'b1, 1,  1'b0, 1'b0, 32'd1};
        vt[5]  = '{48'd100, 32'd0,           1'b1, 1,  1'b0, 1'b0, 32'd1};
        vt[6]  = '{48'd100, 32'd0,           1'b1, 1,  1'b0, 1'b1, 32'd1};
        vt[7]  = '{48'd100, 32'd500,         1'b1, 1,  1'b0, 1'b0, 32'd1};
        vt[8]  = '{48'd100, 32'd100,         1'b1, 1,  1'b0, 1'b0, 32'd1};
        vt[9]  = '{48'd100, 32'd100,         1'b1, 1,  1'b0, 1'b1, 32'd1};
        vt[10] = '{48'd100, 32'd100,         1'b1, 1,  1'b0, 1'b0, 32'd1};
        vt[11] = '{48'd101, 32'd0,           1'b0, 1,  1'b0, 1'b0, 32'd1};
        vt[12] = '{48'd101, 32'd0,           1'b0, 1,  1'b0, 1'b0, 32'd1};
        vt[13] = '{48'd102, 32'd0,           1'b1, 1,  1'b0, 1'b0, 32'd1};
        vt[14] = '{48'd103, 32'd0,           1'b1, 1,  1'b1, 1'b0, 32'd2};
        vt[15] = '{48'd103, 32'd0,           1'b1, 1,  1'b1, 1'b0, 32'd3};
        vt[16] = '{48'd103, 32'd0,           1'b0, 15, 1'b1, 1'b0, 32'd3};
        vt[17] = '{48'd103, 32'd0,           1'b0, 1,  1'b0, 1'b0, 32'd3};

        rst = 1'b1; in_ns = 32'd0; in_sec = 48'd0; pps_en = 1'b0;
        tgt_ld = 1'b0; tgt_sec_i = 48'd0; tgt_ns_i = 32'd0; tgt_cancel = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // PPS on rollover, pulse width, jumps, disabled rollover, retrigger.
        for (int v = 0; v < 18; v++) begin
            for (int r = 0; r < vt[v].reps; r++) begin
                in_sec = vt[v].sec; in_ns = vt[v].ns; pps_en = vt[v].en;
                step();
                chk($sformatf("vec%0d_pps_out", v),   64'(pps_out),   64'(vt[v].pps));
                chk($sformatf("vec%0d_time_jump", v), 64'(time_jump), 64'(vt[v].jump));
                chk($sformatf("vec%0d_pps_cnt", v),   64'(pps_cnt),   64'(vt[v].cnt));
            end
        end

        // Target reached while ramping in 8 ns steps.
        do_reset();
        in_sec = 48'd10; in_ns = 32'd0; pps_en = 1'b1;
        repeat (3) step();
        tgt_sec_i = 48'd10; tgt_ns_i = 32'd500; tgt_ld = 1'b1;
        step();
        tgt_ld = 1'b0;
        chk("t3_armed_after_ld", 64'(tgt_armed), 64'd1);
        n_fire = 0; n_trig = 0; fire_ns = -1; last_ns = in_ns;
        for (int i = 0; i < 80; i++) begin
            in_ns = in_ns + 32'd8;
            step();
            if (tgt_fire) fire_ns = int'(last_ns);
            last_ns = in_ns;
        end
        chk("t3_fire_count", 64'(n_fire), 64'd1);
        chk("t3_fire_ns",    64'(fire_ns), 64'd504);
        chk("t3_trig_width", 64'(n_trig), 64'd4);
        chk("t3_late",       64'(tgt_late), 64'd0);
        chk("t3_armed_end",  64'(tgt_armed), 64'd0);

        // Target already in the past when armed.
        in_sec = 48'd20; in_ns = 32'd0;
        repeat (2) step();
        tgt_sec_i = 48'd19; tgt_ns_i = 32'd0; tgt_ld = 1'b1;
        step();
        tgt_ld = 1'b0;
        step();
        chk("t4_fire", 64'(tgt_fire), 64'd1);
        chk("t4_late", 64'(tgt_late), 64'd1);
        repeat (5) step();
        chk("t4_late_sticky", 64'(tgt_late), 64'd1);

        // Cancel before the target, then load and cancel together.
        in_sec = 48'd28; in_ns = 32'd0;
        repeat (2) step();
        tgt_sec_i = 48'd30; tgt_ns_i = 32'd0; tgt_ld = 1'b1;
        step();
        tgt_ld = 1'b0;
        in_sec = 48'd29; in_ns = 32'd5;
        repeat (2) step();
        chk("t5_armed", 64'(tgt_armed), 64'd1);
        chk("t5_late_cleared", 64'(tgt_late), 64'd0);
        tgt_cancel = 1'b1;
        step();
        tgt_cancel = 1'b0;
        chk("t5_cancelled", 64'(tgt_armed), 64'd0);
        n_fire = 0;
        in_sec = 48'd30; in_ns = 32'd0;
        repeat (3) step();
        in_sec = 48'd31;
        repeat (3) step();
        chk("t5_no_fire", 64'(n_fire), 64'd0);
        tgt_sec_i = 48'd40; tgt_ns_i = 32'd0; tgt_ld = 1'b1; tgt_cancel = 1'b1;
        step();
        tgt_ld = 1'b0; tgt_cancel = 1'b0;
        chk("t5_ld_beats_cancel", 64'(tgt_armed), 64'd1);
        step();
        chk("t5_still_armed", 64'(tgt_armed), 64'd1);

        // Reset in the middle of a PPS pulse while armed; refill behaviour afterwards.
        in_sec = 48'd32;
        repeat (2) step();
        chk("t6_pps_before_rst", 64'(pps_out), 64'd1);
        step();
        do_reset();
        in_sec = 48'd500; in_ns = 32'd900;
        step();
        chk("t6_edge1_pps",  64'(pps_out),   64'd0);
        chk("t6_edge1_jump", 64'(time_jump), 64'd0);
        in_sec = 48'd501; in_ns = 32'd10;
        step();
        chk("t6_edge2_pps",  64'(pps_out),   64'd0);
        chk("t6_edge2_jump", 64'(time_jump), 64'd0);
        in_sec = 48'd502;
        step();
        chk("t6_edge3_pps", 64'(pps_out), 64'd1);
        chk("t6_edge3_cnt", 64'(pps_cnt), 64'd1);

        // Randomized time stream across the 48-bit seconds wrap.
        in_sec = 48'hFFFF_FFFF_FFFD; in_ns = 32'd0;
        for (int i = 0; i < 3000; i++) begin
            int unsigned r;
            if (i == 1500) do_reset();
            r = $urandom_range(0, 99);
            if (r < 4) begin
                in_sec = in_sec + 48'($urandom_range(2, 5));
            end else if (r < 5) begin
                in_sec = in_sec - 48'd1;
            end else if (r < 8) begin
                if (in_ns > 32'd1000) in_ns = in_ns - 32'($urandom_range(1, 1000));
            end else begin
                in_ns = in_ns + 32'($urandom_range(0, 120_000_000));
                if (in_ns >= 32'd1_000_000_000) begin
                    in_ns = in_ns - 32'd1_000_000_000;
                    in_sec = in_sec + 48'd1;
                end
            end
            pps_en     = ($urandom_range(0, 9) != 0);
            tgt_ld     = ($urandom_range(0, 29) == 0);
            tgt_sec_i  = in_sec + 48'($urandom_range(0, 3)) - 48'd1;
            tgt_ns_i   = 32'($urandom_range(0, 999_999_999));
            tgt_cancel = ($urandom_range(0, 39) == 0);
            step();
        end
        tgt_ld = 1'b0; tgt_cancel = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
